i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- I2S receiver: the input-direction counterpart of the SoC's I2S transmit pins (mclk/sdata/sclk/lrclk).
- Acts as an I2S target. Samples an externally driven sclk/lrclk/sdata into the system clock domain and deserialises left/right words.
- Presents complete stereo frames on a valid/ready stream with one-frame holding.
- Sits beside the IO subsystem, fed from pad inputs; its stream output goes to a Wishbone-visible FIFO/DMA.

Parameters:
- SAMPLE_W, 16, captured bits per channel (1..32); output word width.
- TIMEOUT_CYC, 1023, clk cycles without an sclk rising edge before lock is dropped (≥ 16).

Ports:
- clk  in  1  system clock.
- arstn  in  1  asynchronous active-low reset.
- en  in  1  receiver enable.
- i2s_sclk  in  1  external bit clock (asynchronous to clk).
- i2s_lrclk  in  1  word select: 0 = left, 1 = right.
- i2s_sdata  in  1  serial data, MSB first.
- out_left  out  SAMPLE_W  left sample of held frame.
- out_right  out  SAMPLE_W  right sample of held frame.
- out_valid  out  1  held frame valid.
- out_ready  in  1  consumer accepts frame.
- overflow  out  1  sticky: a completed frame was dropped.
- ovf_clr  in  1  clears overflow.
- locked  out  1  receiver aligned to frames (state LEFT or RIGHT).

Behaviour:
- Reset (arstn low, async):
  - All outputs 0; state IDLE; all internal registers 0.
  - Takes effect immediately, including mid-word; partial data is lost.
- Synchronisation:
  - sclk, lrclk and sdata each pass through 2 flip-flops; sclk rising edge is detected from sync stage 2 vs 3.
  - Pin-to-edge-pulse latency is 3 clk.
  - Required: clk ≥ 6× sclk frequency, so lrclk/sdata are stable at the detected edge.
- Bit timing: on each detected sclk rising edge (an "edge"):
  - Sample ws = lrclk_s and bit = sdata_s; ws_d = ws from the previous edge.
  - The bit at an edge belongs to channel ws_d. This implements the I2S one-bit delay.
  - A word starts at an edge where ws_d differs from its value at the edge before.
- Word capture:
  - Bit counter 0..SAMPLE_W, saturating. The first SAMPLE_W bits of a word are shifted in MSB-first.
  - Further bits are ignored.
  - Words shorter than SAMPLE_W are left-justified with zero LSBs.
- FSM states IDLE, SYNC, LEFT, RIGHT:
  - IDLE: entered whenever en=0 (next clk, from any state); shift registers and counter cleared. en=1 → SYNC.
  - SYNC: wait for an edge with ws_d 1→0, then capture that bit as left MSB → LEFT. Partial first frame is never emitted.
  - LEFT: at an edge with ws_d 0→1, latch left word; capture the bit as right MSB → RIGHT.
  - RIGHT: at an edge with ws_d 1→0, latch right word and emit frame {left,right}; capture the bit as left MSB → LEFT.
  - Timeout: in SYNC/LEFT/RIGHT, a cycle counter resets on every edge. Reaching TIMEOUT_CYC → SYNC; partial words discarded; overflow unaffected.
- Output stream:
  - Emitted frame loads out_left/out_right and sets out_valid on the clk after the emitting edge pulse.
  - A frame transfers in a cycle where out_valid && out_ready; out_valid clears the next clk unless a new frame loads in that same cycle. On simultaneous load and transfer, the new frame replaces the old and out_valid stays 1.
  - If a frame is emitted while out_valid=1 and out_ready=0: the new frame is dropped, the held frame is unchanged, and overflow is set.
  - ovf_clr clears overflow; if a set occurs in the same cycle, set wins.
  - A held frame survives en=0 and remains until accepted.
- locked = 1 exactly in LEFT/RIGHT (registered).

Decomposition:
- Shared include i2s_defs: state encoding localparams (IDLE=0, SYNC=1, LEFT=2, RIGHT=3) and the channel encoding constant (WS_LEFT=0).
- Sub-module i2s_rx_sync: three 2-FF synchronisers plus sclk rising-edge pulse; async reset to 0.
- Deserialiser, FSM, timeout counter and output register live in i2s_rx.

Test Plan:
- Nominal, SAMPLE_W=16, 16-bit slots, sclk = clk/8, out_ready=1: send L=16'hA5C3, R=16'h1234 → one frame out_left=A5C3 out_right=1234, 1 clk valid, locked=1 from first left MSB.
- Slot width: 24-bit slots L=24'hABCDEF, R=24'h123456 → out_left=ABCD, out_right=1234.
- Slot width: 8-bit slots L=8'h9F, R=8'h01 → out_left=9F00, out_right=0100.
- Backpressure: out_ready=0 over two frames (1111/2222 then 3333/4444) → held 1111/2222, overflow=1. Then out_ready=1 → 1111/2222 delivered. Pulse ovf_clr → overflow=0.
- Sync/enable: en rises mid-right-word → no output until a full left+right pair. en dropped mid-left → IDLE next clk, locked=0, no partial frame emitted.
- Timeout/reset: stop sclk for 1030 clk → locked=0, state SYNC. Resume → relocks on next 1→0 ws transition. Assert arstn mid-word → all outputs 0 immediately.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// Shared encodings for the I2S receiver: FSM states and the word-select
// channel value that marks the left channel.
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } state_e;

    localparam logic WS_LEFT = 1'b0;

endpackage

// File: rtl/i2s_rx_sync.sv
// Two-flop synchronisers for the I2S pins plus a rising-edge pulse on the
// bit clock, taken from the second and third sclk stages.
module i2s_rx_sync (
    input  logic clk,
    input  logic arstn,
    input  logic sclk_i,
    input  logic lrclk_i,
    input  logic sdata_i,
    output logic sclk_rise_o,
    output logic lrclk_o,
    output logic sdata_o
);

    logic [2:0] sclk_q;
    logic [1:0] lrclk_q;
    logic [1:0] sdata_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sclk_q  <= '0;
            lrclk_q <= '0;
            sdata_q <= '0;
        end else begin
            sclk_q  <= {sclk_q[1:0], sclk_i};
            lrclk_q <= {lrclk_q[0], lrclk_i};
            sdata_q <= {sdata_q[0], sdata_i};
        end
    end

    assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
    assign lrclk_o     = lrclk_q[1];
    assign sdata_o     = sdata_q[1];

endmodule

// File: rtl/i2s_rx.sv
// I2S target receiver: deserialises left/right words from the synchronised
// pins and holds one complete stereo frame on a valid/ready output.
//
// state | meaning
// IDLE  | disabled, capture state cleared
// SYNC  | waiting for a right-to-left word boundary
// LEFT  | capturing the left word
// RIGHT | capturing the right word
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                en,
    input  logic                i2s_sclk,
    input  logic                i2s_lrclk,
    input  logic                i2s_sdata,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overflow,
    input  logic                ovf_clr,
    output logic                locked
);

    localparam int CW = $clog2(SAMPLE_W + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic sclk_rise, lrclk_s, sdata_s;

    i2s_rx_sync u_sync (
        .clk         (clk),
        .arstn       (arstn),
        .sclk_i      (i2s_sclk),
        .lrclk_i     (i2s_lrclk),
        .sdata_i     (i2s_sdata),
        .sclk_rise_o (sclk_rise),
        .lrclk_o     (lrclk_s),
        .sdata_o     (sdata_s)
    );

    state_e              state_q, state_d;
    logic                ws_d_q, ws_dd_q;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] left_q, left_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [SAMPLE_W-1:0] out_left_q, out_left_d;
    logic [SAMPLE_W-1:0] out_right_q, out_right_d;
    logic                out_valid_q, out_valid_d;
    logic                ovf_q, ovf_d;
    logic                locked_q;

    logic                ws_start, timeout, emit;
    logic [SAMPLE_W-1:0] shift_first, shift_app;
    logic [CW-1:0]       cnt_app;

    // The bit at an edge belongs to the channel sampled one edge earlier.
    assign ws_start = (ws_d_q != ws_dd_q);
    assign timeout  = (state_q != ST_IDLE) && !sclk_rise && (tmr_q == '0);

    always_comb begin
        shift_first             = '0;
        shift_first[SAMPLE_W-1] = sdata_s;
        shift_app               = shift_q;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (cnt_q == CW'(SAMPLE_W - 1 - i)) shift_app[i] = sdata_s;
        end
        cnt_app = (cnt_q == CW'(SAMPLE_W)) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                shift_d = '0;
                left_d  = '0;
                cnt_d   = '0;
                state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (sclk_rise && ws_start && ws_d_q == WS_LEFT) begin
                    shift_d = shift_first;
                    cnt_d   = CW'(1);
                    state_d = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (sclk_rise && ws_start && ws_d_q != WS_LEFT) begin
                    left_d  = shift_q;
                    shift_d = shift_first;
                    cnt_d   = CW'(1);
                    state_d = ST_RIGHT;
                end else if (sclk_rise) begin
                    shift_d = shift_app;
                    cnt_d   = cnt_app;
                end
            end
            ST_RIGHT: begin
                if (sclk_rise && ws_start && ws_d_q == WS_LEFT) begin
                    emit    = 1'b1;
                    shift_d = shift_first;
                    cnt_d   = CW'(1);
                    state_d = ST_LEFT;
                end else if (sclk_rise) begin
                    shift_d = shift_app;
                    cnt_d   = cnt_app;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) begin
            shift_d = '0;
            left_d  = '0;
            cnt_d   = '0;
            state_d = ST_SYNC;
        end
        if (!en) state_d = ST_IDLE;
    end

    always_comb begin
        tmr_d = tmr_q - 1'b1;
        if (state_q == ST_IDLE || sclk_rise || timeout) tmr_d = TW'(TIMEOUT_CYC - 1);
    end

    // A new frame only lands when the holding slot is free or being drained.
    always_comb begin
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (ovf_clr) ovf_d = 1'b0;
        if (emit) begin
            if (!out_valid_q || out_ready) begin
                out_left_d  = left_q;
                out_right_d = shift_q;
                out_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= ST_IDLE;
            ws_d_q      <= 1'b0;
            ws_dd_q     <= 1'b0;
            shift_q     <= '0;
            left_q      <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (sclk_rise) begin
                ws_d_q  <= lrclk_s;
                ws_dd_q <= ws_d_q;
            end
            shift_q     <= shift_d;
            left_q      <= left_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            locked_q    <= (state_d == ST_LEFT) || (state_d == ST_RIGHT);
        end
    end

    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;
    assign overflow  = ovf_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives an I2S transmitter model at clk/8 and
// checks frames, backpressure, enable, timeout and reset behaviour.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        en = 1'b0;
    logic        i2s_sclk = 1'b1;
    logic        i2s_lrclk = 1'b0;
    logic        i2s_sdata = 1'b0;
    logic [15:0] out_left, out_right;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic        locked;

    int passed = 0;
    int total  = 0;
    int valid_cycles = 0;
    logic [15:0] got_l[$];
    logic [15:0] got_r[$];

    typedef struct {
        int          w;
        logic [31:0] l;
        logic [31:0] r;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    vec_t vecs[6];

    i2s_rx #(.SAMPLE_W(16), .TIMEOUT_CYC(1023)) dut (
        .clk       (clk),
        .arstn     (arstn),
        .en        (en),
        .i2s_sclk  (i2s_sclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata),
        .out_left  (out_left),
        .out_right (out_right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (arstn && out_valid === 1'b1) begin
            valid_cycles++;
            if (out_ready) begin
                got_l.push_back(out_left);
                got_r.push_back(out_right);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send_bit(input logic ws, input logic b);
        @(posedge clk);
        #2;
        i2s_sclk  = 1'b0;
        i2s_lrclk = ws;
        i2s_sdata = b;
        repeat (4) @(posedge clk);
        #2;
        i2s_sclk = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // Word select flips during the last bit of a slot (one-bit I2S delay).
    task automatic send_word(input int w, input logic [31:0] data, input logic ch);
        for (int i = 0; i < w; i++)
            send_bit((i == w - 1) ? ~ch : ch, data[w - 1 - i]);
    endtask

    task automatic send_frame(input int w, input logic [31:0] l, input logic [31:0] r);
        send_word(w, l, 1'b0);
        send_word(w, r, 1'b1);
    endtask

    task automatic trail();
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        repeat (6) @(posedge clk);
    endtask

    task automatic resync();
        en = 1'b0;
        repeat (3) @(posedge clk);
        en = 1'b1;
        send_word(4, 32'h0, 1'b1);
    endtask

    initial begin
        vecs[0] = '{16, 32'hA5C3,     32'h1234,     16'hA5C3, 16'h1234};
        vecs[1] = '{24, 32'hABCDEF,   32'h123456,   16'hABCD, 16'h1234};
        vecs[2] = '{8,  32'h9F,       32'h01,       16'h9F00, 16'h0100};
        vecs[3] = '{17, 32'h12345,    32'h00001,    16'h91A2, 16'h0000};
        vecs[4] = '{4,  32'hA,        32'h5,        16'hA000, 16'h5000};
        vecs[5] = '{32, 32'hDEADBEEF, 32'h0F1E2D3C, 16'hDEAD, 16'h0F1E};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_left", out_left, 0);
        chk("rst_right", out_right, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_locked", locked, 0);
        arstn = 1'b1;
        en = 1'b1;
        repeat (3) @(posedge clk);

        // nominal stream, table driven
        send_word(4, 32'h0, 1'b1);
        chk("pre_lock", locked, 0);
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].w, vecs[i].l, vecs[i].r);
            chk($sformatf("lock_v%0d", i), locked, 1);
        end
        trail();
        chk("nom_count", got_l.size(), 6);
        chk("nom_valid_cycles", valid_cycles, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_l.size()) begin
                chk($sformatf("v%0d_left", i), got_l[i], vecs[i].el);
                chk($sformatf("v%0d_right", i), got_r[i], vecs[i].er);
            end else begin
                chk($sformatf("v%0d_present", i), 0, 1);
            end
        end

        // backpressure and overflow
        resync();
        got_l.delete();
        got_r.delete();
        out_ready = 1'b0;
        send_frame(16, 32'h1111, 32'h2222);
        send_frame(16, 32'h3333, 32'h4444);
        trail();
        chk("bp_valid", out_valid, 1);
        chk("bp_left", out_left, 16'h1111);
        chk("bp_right", out_right, 16'h2222);
        chk("bp_ovf", overflow, 1);
        chk("bp_none_taken", got_l.size(), 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_drain_count", got_l.size(), 1);
        if (got_l.size() > 0) begin
            chk("bp_drain_left", got_l[0], 16'h1111);
            chk("bp_drain_right", got_r[0], 16'h2222);
        end
        chk("bp_valid_clr", out_valid, 0);
        chk("bp_ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // enable rises mid right word
        en = 1'b0;
        repeat (3) @(posedge clk);
        got_l.delete();
        got_r.delete();
        fork
            send_frame(16, 32'hDEAD, 32'hBEEF);
            begin
                repeat (192) @(posedge clk);
                en = 1'b1;
            end
        join
        chk("en_mid_nolock", locked, 0);
        send_frame(16, 32'h5A5A, 32'hC3C3);
        trail();
        chk("en_count", got_l.size(), 1);
        if (got_l.size() > 0) begin
            chk("en_left", got_l[0], 16'h5A5A);
            chk("en_right", got_r[0], 16'hC3C3);
        end

        // enable dropped mid left word
        got_l.delete();
        got_r.delete();
        fork
            send_frame(16, 32'h6666, 32'h7777);
            begin
                repeat (64) @(posedge clk);
                #1 chk("endrop_pre_lock", locked, 1);
                en = 1'b0;
                repeat (2) @(posedge clk);
                #1 chk("endrop_lock", locked, 0);
            end
        join
        trail();
        chk("endrop_count", got_l.size(), 0);

        // timeout and relock
        resync();
        got_l.delete();
        got_r.delete();
        send_frame(16, 32'h1357, 32'h2468);
        trail();
        chk("to_count1", got_l.size(), 1);
        chk("to_lock_before", locked, 1);
        repeat (1030) @(posedge clk);
        #1 chk("to_lock_after", locked, 0);
        send_word(4, 32'h0, 1'b1);
        chk("to_no_early_lock", locked, 0);
        send_frame(16, 32'h0F0F, 32'hF0F0);
        chk("to_relock", locked, 1);
        trail();
        chk("to_count2", got_l.size(), 2);
        if (got_l.size() > 1) begin
            chk("to_left", got_l[1], 16'h0F0F);
            chk("to_right", got_r[1], 16'hF0F0);
        end

        // async reset mid word with a held frame
        resync();
        out_ready = 1'b0;
        send_frame(16, 32'h7777, 32'h8888);
        fork
            send_frame(16, 32'h9999, 32'hAAAA);
            begin
                repeat (60) @(posedge clk);
                #3;
                chk("ar_pre_valid", out_valid, 1);
                chk("ar_pre_left", out_left, 16'h7777);
                arstn = 1'b0;
                #1;
                chk("ar_valid", out_valid, 0);
                chk("ar_left", out_left, 0);
                chk("ar_right", out_right, 0);
                chk("ar_ovf", overflow, 0);
                chk("ar_locked", locked, 0);
            end
        join
        repeat (3) @(posedge clk);
        #1 chk("ar_hold_valid", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
